// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter guarding one shared WIDTH-bit register.
// One requester owns the register at a time: IDLE picks a winner starting
// at the rotating pointer, GRANT performs the single write, and RELEASE holds
// ownership until the owner drops its request.
module dff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic                     wr_done,
    output logic [IDX_W-1:0]         owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               wr_done_q, wr_done_d;
    logic [WIDTH-1:0]   q_q, q_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [WIDTH-1:0]   slice [N_REQ];
    logic [WIDTH-1:0]   own_slice;

    // Unpack the write data so the owner's slice can be picked by index.
    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slice[i] = wdata[i*WIDTH +: WIDTH];
    end
    assign own_slice = slice[owner_q];

    // Rotating priority search: first requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // Next-state logic; a grant that is abandoned in GRANT keeps ptr advanced.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        wr_done_d = 1'b0;
        q_d       = q_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    ptr_d          = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    q_d       = own_slice;
                    wr_done_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any write due this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            wr_done_q <= 1'b0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            wr_done_q <= wr_done_d;
            q_q       <= q_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_done = wr_done_q;
    assign owner   = owner_q;
    assign busy    = (state_q != IDLE);
    assign q       = q_q;
    assign qbr     = ~q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (N_REQ=4, WIDTH=8).
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        wr_done;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qbr;

    int n_pass  = 0;
    int n_total = 0;

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
        .wr_done(wr_done), .owner(owner), .busy(busy), .q(q), .qbr(qbr)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; wdata = 32'h44332211;
        tick(); tick();
        n_total++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++; if (q !== 8'h00) $display("FAIL rst_q: got %h want 00", q); else n_pass++;
        n_total++; if (qbr !== 8'hFF) $display("FAIL rst_qbr: got %h want ff", qbr); else n_pass++;
        n_total++; if (busy !== 1'b0 || wr_done !== 1'b0 || owner !== 2'd0)
            $display("FAIL rst_ctl: got busy=%b wr_done=%b owner=%0d want 0/0/0", busy, wr_done, owner); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (gnt !== 4'b0001 || busy !== 1'b1) $display("FAIL rst_first_gnt: got %b busy=%b want 0001 busy=1", gnt, busy); else n_pass++;
        tick();
        n_total++; if (q !== 8'h11 || wr_done !== 1'b1) $display("FAIL rst_first_wr: got q=%h wr_done=%b want 11/1", q, wr_done); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++; if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL rst_release: got %b busy=%b want 0000/0", gnt, busy); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        wdata = 32'h00A50000; req = 4'b0100;
        tick();
        n_total++; if (gnt !== 4'b0100 || owner !== 2'd2 || q !== 8'h00)
            $display("FAIL single_gnt: got gnt=%b owner=%0d q=%h want 0100/2/00", gnt, owner, q); else n_pass++;
        tick();
        n_total++; if (q !== 8'hA5 || qbr !== 8'h5A || wr_done !== 1'b1)
            $display("FAIL single_wr: got q=%h qbr=%h wr_done=%b want a5/5a/1", q, qbr, wr_done); else n_pass++;
        wdata = 32'h00FF0000;
        tick();
        n_total++; if (wr_done !== 1'b0 || gnt !== 4'b0100 || q !== 8'hA5)
            $display("FAIL single_hold: got wr_done=%b gnt=%b q=%h want 0/0100/a5", wr_done, gnt, q); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++; if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'hA5)
            $display("FAIL single_drop: got gnt=%b busy=%b q=%h want 0000/0/a5", gnt, busy, q); else n_pass++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        wdata = 32'h44332211; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic       got;
            logic [3:0] eg;
            logic [7:0] eq;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                if (gnt != 4'b0000) got = 1'b1;
            end
            eg = 4'b0001 << order[k];
            eq = 8'h11 * 8'(order[k] + 1);
            n_total++; if (!got || gnt !== eg) $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, eg); else n_pass++;
            tick();
            n_total++; if (q !== eq || qbr !== ~eq || wr_done !== 1'b1)
                $display("FAIL rr_q%0d: got q=%h qbr=%h wr_done=%b want %h/%h/1", k, q, qbr, wr_done, eq, ~eq); else n_pass++;
            req[order[k]] = 1'b0;
            tick();
            req[order[k]] = 1'b1;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        wdata = 32'h44332211; req = 4'b0100;
        tick(); tick();
        req = 4'b0000;
        tick();
        req = 4'b0011;
        tick();
        n_total++; if (gnt !== 4'b0001) $display("FAIL wrap_gnt0: got %b want 0001", gnt); else n_pass++;
        tick();
        n_total++; if (q !== 8'h11) $display("FAIL wrap_q0: got %h want 11", q); else n_pass++;
        req = 4'b0010;
        tick(); tick();
        n_total++; if (gnt !== 4'b0010) $display("FAIL wrap_gnt1: got %b want 0010", gnt); else n_pass++;
        tick();
        n_total++; if (q !== 8'h22) $display("FAIL wrap_q1: got %h want 22", q); else n_pass++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abandon();
        do_reset();
        wdata = 32'h44337711; req = 4'b0010;
        tick();
        n_total++; if (gnt !== 4'b0010) $display("FAIL abandon_gnt: got %b want 0010", gnt); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++; if (gnt !== 4'b0000 || busy !== 1'b0 || wr_done !== 1'b0 || q !== 8'h00)
            $display("FAIL abandon_idle: got gnt=%b busy=%b wr_done=%b q=%h want 0000/0/0/00", gnt, busy, wr_done, q); else n_pass++;
        tick();
        n_total++; if (wr_done !== 1'b0 || q !== 8'h00) $display("FAIL abandon_nowr: got wr_done=%b q=%h want 0/00", wr_done, q); else n_pass++;
        req = 4'b0111;
        tick();
        n_total++; if (gnt !== 4'b0100) $display("FAIL abandon_ptr: got %b want 0100", gnt); else n_pass++;
        tick();
        n_total++; if (q !== 8'h33) $display("FAIL abandon_q: got %h want 33", q); else n_pass++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        wdata = 32'h443322FF; req = 4'b0001;
        tick();
        n_total++; if (gnt !== 4'b0001) $display("FAIL rmid_gnt: got %b want 0001", gnt); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (q !== 8'h00 || qbr !== 8'hFF || gnt !== 4'b0000 || wr_done !== 1'b0)
            $display("FAIL rmid_state: got q=%h qbr=%h gnt=%b wr_done=%b want 00/ff/0000/0", q, qbr, gnt, wr_done); else n_pass++;
        rst = 1'b0; req = 4'b0011;
        tick();
        n_total++; if (gnt !== 4'b0001 || wr_done !== 1'b0) $display("FAIL rmid_ptr: got gnt=%b wr_done=%b want 0001/0", gnt, wr_done); else n_pass++;
        req = 4'b0000;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_abandon();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
